// File: rtl/wrap_updown_counter_pkg.sv
// Shared clock-field definitions: repeat FSM states, button direction,
// calendar field bounds and a timer sizing helper.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } rpt_state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_e;

  localparam int YEAR_MIN    = 2025;
  localparam int YEAR_MAX    = 3025;
  localparam int MONTH_MIN   = 1;
  localparam int MONTH_MAX   = 12;
  localparam int HOUR_MIN    = 0;
  localparam int HOUR_MAX    = 23;
  localparam int MIN_SEC_MIN = 0;
  localparam int MIN_SEC_MAX = 59;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int timer_w(input int h, input int r);
    return $clog2(max_int(h, r) + 1);
  endfunction

endpackage

// File: rtl/wrap_updown_counter_if.sv
// Control/status bundle of one wrapping clock field.
// master drives buttons, tick and load; slave is the counter.
interface wrap_updown_counter_if #(
  parameter int WIDTH = 14
);
  logic             manual_set;
  logic             up;
  logic             down;
  logic             tick;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] value;
  logic             wrap_up;
  logic             wrap_down;
  logic             at_max;
  logic             at_min;

  modport master (
    output manual_set, up, down, tick, load, load_val,
    input  value, wrap_up, wrap_down, at_max, at_min
  );

  modport slave (
    input  manual_set, up, down, tick, load, load_val,
    output value, wrap_up, wrap_down, at_max, at_min
  );
endinterface

// File: rtl/wrap_updown_counter_button_repeat.sv
// Press-and-hold auto-repeat for the up/down buttons.
// Emits one step on press, after HOLD_CYCLES, then every REPEAT_CYCLES.
module button_repeat
  import clock_pkg::*;
#(
  parameter int HOLD_CYCLES   = 4,
  parameter int REPEAT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic up,
  input  logic down,
  output logic step_up,
  output logic step_down
);

  localparam int TW = timer_w(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [TW-1:0] HOLD_T = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] REP_T  = TW'(REPEAT_CYCLES);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  rpt_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  dir_e          dir_q, dir_d, dir;
  logic          fire;

  always_comb begin
    dir = DIR_NONE;
    unique case (1'b1)
      up && !down: dir = DIR_UP;
      down && !up: dir = DIR_DOWN;
      default:     dir = DIR_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      dir_q   <= DIR_NONE;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
    end
  end

  // A direction change while held restarts the press sequence.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    fire    = 1'b0;
    if (!en || dir == DIR_NONE) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (state_q == IDLE || dir != dir_q) begin
      fire    = 1'b1;
      state_d = HELD;
      timer_d = T_ONE;
      dir_d   = dir;
    end else begin
      unique case (state_q)
        HELD: begin
          if (timer_q == HOLD_T) begin
            fire    = 1'b1;
            state_d = REPEAT;
            timer_d = T_ONE;
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
        REPEAT: begin
          if (timer_q == REP_T) begin
            fire    = 1'b1;
            timer_d = T_ONE;
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  assign step_up   = fire && (dir == DIR_UP);
  assign step_down = fire && (dir == DIR_DOWN);

endmodule

// File: rtl/wrap_updown_counter.sv
// Bounded MIN..MAX counter with wrap pulses, run-mode tick advance
// and manual stepping/loading for a clock calendar field.
module wrap_updown_counter
  import clock_pkg::*;
#(
  parameter int WIDTH         = 14,
  parameter int MIN           = YEAR_MIN,
  parameter int MAX           = YEAR_MAX,
  parameter int RESET_VAL     = YEAR_MIN,
  parameter int HOLD_CYCLES   = 4,
  parameter int REPEAT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  wrap_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] LO    = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] HI    = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             rpt_en;
  logic             step_up, step_down;
  logic             do_load, do_inc, do_dec;
  logic [WIDTH-1:0] clamped;
  logic [WIDTH-1:0] value_q, value_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_down_q, wrap_down_d;

  assign rpt_en = bus.manual_set & ~bus.load;

  button_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_rpt (
    .clk      (clk),
    .rst      (rst),
    .en       (rpt_en),
    .up       (bus.up),
    .down     (bus.down),
    .step_up  (step_up),
    .step_down(step_down)
  );

  always_comb begin
    do_load = 1'b0;
    do_inc  = 1'b0;
    do_dec  = 1'b0;
    if (!bus.manual_set) begin
      do_inc = bus.tick;
    end else if (bus.load) begin
      do_load = 1'b1;
    end else begin
      do_inc = step_up;
      do_dec = step_down;
    end
  end

  assign clamped = (bus.load_val > HI) ? HI :
                   (bus.load_val < LO) ? LO : bus.load_val;

  always_comb begin
    value_d     = value_q;
    wrap_up_d   = 1'b0;
    wrap_down_d = 1'b0;
    unique case (1'b1)
      do_load: value_d = clamped;
      do_inc: begin
        if (value_q == HI) begin
          value_d   = LO;
          wrap_up_d = 1'b1;
        end else begin
          value_d = value_q + ONE;
        end
      end
      do_dec: begin
        if (value_q == LO) begin
          value_d     = HI;
          wrap_down_d = 1'b1;
        end else begin
          value_d = value_q - ONE;
        end
      end
      default: value_d = value_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q     <= RST_V;
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
    end else begin
      value_q     <= value_d;
      wrap_up_q   <= wrap_up_d;
      wrap_down_q <= wrap_down_d;
    end
  end

  assign bus.value     = value_q;
  assign bus.wrap_up   = wrap_up_q;
  assign bus.wrap_down = wrap_down_q;
  assign bus.at_max    = (value_q == HI);
  assign bus.at_min    = (value_q == LO);

endmodule

// File: tb/tb_wrap_updown_counter.sv
// Scoreboard bench for wrap_updown_counter: year-sized and 1..12 instances
// checked every cycle against a press-age behavioural model.
module tb_wrap_updown_counter;

  localparam int W0  = 14;
  localparam int LO0 = 2025;
  localparam int HI0 = 3025;
  localparam int RV0 = 2025;
  localparam int W1  = 4;
  localparam int LO1 = 1;
  localparam int HI1 = 12;
  localparam int RV1 = 1;
  localparam int H   = 4;
  localparam int R   = 2;

  typedef struct {
    int id;
    int val;
    bit wu;
    bit wd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wrap_updown_counter_if #(.WIDTH(W0)) bus0();
  wrap_updown_counter_if #(.WIDTH(W1)) bus1();

  wrap_updown_counter #(
    .WIDTH(W0), .MIN(LO0), .MAX(HI0), .RESET_VAL(RV0),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  wrap_updown_counter #(
    .WIDTH(W1), .MIN(LO1), .MAX(HI1), .RESET_VAL(RV1),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  string phase = "reset";
  exp_t  exp_q[$];
  int    m_val[2];
  int    m_cnt[2];
  int    m_dir[2];
  int    lo[2] = '{LO0, LO1};
  int    hi[2] = '{HI0, HI1};
  int    rv[2] = '{RV0, RV1};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s.%s observed %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  // m_cnt = edges since the current press was first sampled (-1 = none)
  task automatic model(input int id, input bit ms, input bit u, input bit d,
                       input bit t, input bit ld, input int lv,
                       output exp_t e);
    int dir;
    bit inc, dec;
    e.id = id; e.wu = 0; e.wd = 0; inc = 0; dec = 0;
    if (!ms) begin
      m_cnt[id] = -1;
      inc = t;
    end else if (ld) begin
      m_cnt[id] = -1;
      m_val[id] = (lv > hi[id]) ? hi[id] : (lv < lo[id]) ? lo[id] : lv;
    end else begin
      dir = (u && !d) ? 1 : (d && !u) ? 2 : 0;
      if (dir == 0) begin
        m_cnt[id] = -1;
      end else begin
        if (m_cnt[id] < 0 || dir != m_dir[id]) m_cnt[id] = 0;
        else m_cnt[id]++;
        m_dir[id] = dir;
        if (m_cnt[id] == 0 || m_cnt[id] == H ||
            (m_cnt[id] > H && (m_cnt[id] - H) % R == 0)) begin
          inc = (dir == 1);
          dec = (dir == 2);
        end
      end
    end
    if (inc) begin
      if (m_val[id] == hi[id]) begin m_val[id] = lo[id]; e.wu = 1; end
      else m_val[id]++;
    end
    if (dec) begin
      if (m_val[id] == lo[id]) begin m_val[id] = hi[id]; e.wd = 1; end
      else m_val[id]--;
    end
    e.val = m_val[id];
  endtask

  task automatic cyc(input int id, input bit ms, input bit u, input bit d,
                     input bit t, input bit ld, input int lv);
    exp_t e;
    bit   me;
    int   ov;
    bit   owu, owd, oam, oan;
    for (int k = 0; k < 2; k++) begin
      me = (k == id);
      model(k, me && ms, me && u, me && d, me && t, me && ld,
            me ? lv : 0, e);
      if (me) exp_q.push_back(e);
    end
    bus0.manual_set = (id == 0) && ms;
    bus0.up         = (id == 0) && u;
    bus0.down       = (id == 0) && d;
    bus0.tick       = (id == 0) && t;
    bus0.load       = (id == 0) && ld;
    bus0.load_val   = (id == 0) ? W0'(lv) : '0;
    bus1.manual_set = (id == 1) && ms;
    bus1.up         = (id == 1) && u;
    bus1.down       = (id == 1) && d;
    bus1.tick       = (id == 1) && t;
    bus1.load       = (id == 1) && ld;
    bus1.load_val   = (id == 1) ? W1'(lv) : '0;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      if (e.id == 0) begin
        ov = int'(bus0.value); owu = bus0.wrap_up; owd = bus0.wrap_down;
        oam = bus0.at_max; oan = bus0.at_min;
      end else begin
        ov = int'(bus1.value); owu = bus1.wrap_up; owd = bus1.wrap_down;
        oam = bus1.at_max; oan = bus1.at_min;
      end
      chk("value", ov, e.val);
      chk("wrap_up", owu, e.wu);
      chk("wrap_down", owd, e.wd);
      chk("at_max", oam, e.val == hi[e.id]);
      chk("at_min", oan, e.val == lo[e.id]);
    end
  endtask

  // Reset pulse placed between clock edges, checked before any edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("arst.value0", bus0.value, RV0);
    chk("arst.wrap_up0", bus0.wrap_up, 0);
    chk("arst.wrap_down0", bus0.wrap_down, 0);
    chk("arst.value1", bus1.value, RV1);
    for (int k = 0; k < 2; k++) begin
      m_val[k] = rv[k];
      m_cnt[k] = -1;
    end
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_val[k] = rv[k];
      m_cnt[k] = -1;
      m_dir[k] = 0;
    end
    bus0.manual_set = 0; bus0.up = 0; bus0.down = 0;
    bus0.tick = 0; bus0.load = 0; bus0.load_val = '0;
    bus1.manual_set = 0; bus1.up = 0; bus1.down = 0;
    bus1.tick = 0; bus1.load = 0; bus1.load_val = '0;
    #2 rst = 1'b1;
    #2;
    chk("value0", bus0.value, RV0);
    chk("wrap_up0", bus0.wrap_up, 0);
    chk("wrap_down0", bus0.wrap_down, 0);
    chk("at_min0", bus0.at_min, 1);
    chk("at_max0", bus0.at_max, 0);
    chk("value1", bus1.value, RV1);
    @(posedge clk);
    #1 rst = 1'b0;

    phase = "t1_run";
    for (int i = 0; i < 1000; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    chk("at_3025", bus0.value, 3025);
    chk("at_max_flag", bus0.at_max, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("wrapped", bus0.wrap_up, 1);
    cyc(0, 0, 1, 1, 0, 1, 77);
    chk("pulse_gone", bus0.wrap_up, 0);

    phase = "t2_manual_wrap";
    cyc(0, 1, 0, 1, 0, 0, 0);
    chk("down_wrap", bus0.value, 3025);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("up_wrap", bus0.value, 2025);
    cyc(0, 1, 0, 0, 0, 0, 0);

    phase = "t3_hold";
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, i[0], 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    chk("final", bus0.value, 2029);

    phase = "t4_load";
    cyc(0, 1, 0, 0, 0, 1, 5000);
    chk("clamp_hi", bus0.value, 3025);
    cyc(0, 1, 0, 0, 0, 1, 100);
    chk("clamp_lo", bus0.value, 2025);
    cyc(0, 1, 1, 0, 0, 1, 2500);
    chk("load_wins", bus0.value, 2500);
    cyc(0, 1, 0, 0, 0, 0, 0);

    phase = "t5_both";
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 1, 0, 0, 0);
    chk("unchanged", bus0.value, 2500);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("new_press", bus0.value, 2501);
    cyc(0, 1, 0, 0, 0, 0, 0);

    phase = "t6_reset";
    cyc(0, 1, 0, 0, 0, 1, 2025);
    for (int i = 0; i < 100 && m_val[0] != 2040; i++)
      cyc(0, 1, 1, 0, 0, 0, 0);
    chk("reached", bus0.value, 2040);
    async_reset();
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0, 0, 0);
    chk("after_rst", bus0.value, 2027);
    cyc(0, 1, 0, 0, 0, 0, 0);

    phase = "u4";
    for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0, 1, 0, 0);
    chk("at_12", bus1.value, 12);
    chk("at_max_flag", bus1.at_max, 1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("wrap_to_1", bus1.value, 1);
    cyc(1, 1, 0, 1, 0, 0, 0);
    chk("down_wrap", bus1.value, 12);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("up_wrap", bus1.value, 1);
    cyc(1, 1, 0, 0, 0, 1, 15);
    chk("clamp_hi", bus1.value, 12);
    cyc(1, 1, 0, 0, 0, 1, 0);
    chk("clamp_lo", bus1.value, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wrap_updown_counter.md
Name: wrap_updown_counter

Overview:
Parametrised bounded counter that wraps between MIN and MAX. It is the generic successor of the calendar field counters (year, month, day, hour, minute) in the digital clock. It has two modes. In run mode it advances on a tick from the lower-order field. In manual-set mode it steps on up/down buttons, with press-and-hold auto-repeat, and it accepts a direct load. Single-cycle wrap pulses cascade to the next field.

Parameters:
WIDTH, 14, counter width in bits; must satisfy MAX < 2**WIDTH
MIN, 2025, lowest legal value
MAX, 3025, highest legal value; MIN < MAX required
RESET_VAL, 2025, value after reset; must lie in [MIN, MAX]
HOLD_CYCLES, 4, cycles a button must stay held before auto-repeat starts (>= 1)
REPEAT_CYCLES, 2, cycles between auto-repeat steps (>= 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
manual_set  input  1  1 = manual mode (buttons and load active, tick ignored)
up  input  1  increment button, level; already debounced and synchronised
down  input  1  decrement button, level; already debounced and synchronised
tick  input  1  run-mode advance request, one-cycle pulse
load  input  1  direct load strobe; acts in manual mode only
load_val  input  WIDTH  value to load
value  output  WIDTH  current count
wrap_up  output  1  one-cycle pulse: value went MAX -> MIN this edge
wrap_down  output  1  one-cycle pulse: value went MIN -> MAX this edge
at_max  output  1  combinational, value == MAX
at_min  output  1  combinational, value == MIN

Behaviour:
- Reset, asynchronous, any time including mid-repeat: value = RESET_VAL, wrap_up = wrap_down = 0, FSM = IDLE, hold timer = 0.
- Increment: value == MAX -> MIN with wrap_up = 1; otherwise value + 1.
- Decrement: value == MIN -> MAX with wrap_down = 1; otherwise value - 1.
- The wrap pulses are registered. They are high only in the cycle following the wrapping edge and are 0 on all other edges.
- Run mode (manual_set = 0): tick = 1 -> increment. up, down, load are ignored. FSM is forced to IDLE.
- Manual mode (manual_set = 1): tick is ignored.
  - Priority: load > button stepping.
  - load = 1: value = load_val clamped (> MAX -> MAX, < MIN -> MIN). No wrap pulse. FSM -> IDLE.
- Button direction dir:
  - up only -> +1; down only -> -1.
  - Both high or neither high -> no step, FSM -> IDLE.
  - A change of dir while held counts as a new press.
- Auto-repeat FSM, counted on edges where the button is sampled high:
  - IDLE: a button is sampled active -> one step at that edge; go to HELD; timer = 1.
  - HELD: timer increments each cycle. When timer == HOLD_CYCLES -> step; go to REPEAT; timer = 1.
  - REPEAT: timer increments. When timer == REPEAT_CYCLES -> step; timer = 1.
  - Button released in any state -> IDLE without a step.
- Resulting step edges for a press first sampled at edge k: k, k+HOLD_CYCLES, then every REPEAT_CYCLES after that.
- manual_set falling while a button is held: FSM -> IDLE that edge. The same edge may take a tick step.
- Latency: every update is visible on value one edge after the sampled input. at_max and at_min follow value combinationally.
- Timer width: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES) + 1). Arithmetic is WIDTH bits with no overflow outside [MIN, MAX].

Decomposition:
- Shared package clock_pkg holds:
  - FSM state typedef {IDLE, HELD, REPEAT}.
  - Field bound constants (YEAR_MIN = 2025, YEAR_MAX = 3025, MONTH 1..12, HOUR 0..23, MIN_SEC 0..59).
- One sub-module: button_repeat. It holds the FSM and timer, takes up/down/enable, and emits step_up/step_down pulses. The top module holds the value register, the load clamp and the wrap logic.

Test Plan:
All tests use default parameters unless noted.
1. Reset then 1000 ticks in run mode -> value 3025 and at_max = 1; next tick -> value 2025, wrap_up high for exactly one cycle.
2. Manual mode, value 2025, single-cycle down -> value 3025, wrap_down pulse; single-cycle up -> 2025, wrap_up pulse.
3. Manual mode, up held 10 cycles from 2025 -> steps at edges k, k+4, k+6, k+8, final value 2029; tick pulses during the hold have no effect.
4. Manual mode, load with load_val = 5000 -> 3025; load_val = 100 -> 2025; load and up together -> load wins, no extra step, no wrap pulses.
5. up and down both high for 6 cycles -> value unchanged; release down with up still held -> treated as a new press, immediate +1.
6. Assert rst during REPEAT at value 2040 -> value 2025 immediately without waiting for clk; after release, up still held -> new press, step at first edge, then 4-cycle hold before repeat. Repeat with WIDTH = 4, MIN = 1, MAX = 12 -> 12 -> 1 wrap correct.
